core_lsu: RTL
=============

# core_lsu

Load/store unit sitting directly downstream of the execute stage. It accepts one memory operation per transaction (the address is already computed by the ALU as rs1+imm) and drives a single-outstanding req/ack data-memory bus. It lane-aligns store data, extracts and sign- or zero-extends load data, and returns load results to the register write port. While a transaction is in flight it requests a pipeline hold.

## Interface
- `ADDR_W`, default 32: data address width.
- `TIMEOUT`, default 255: maximum number of cycles to wait for `mem_ack_in` before aborting.
- `clk` in 1: core clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_in` in 1: execute stage presents a memory operation.
- `req_ready_out` out 1: LSU is able to accept an operation; high only in IDLE.
- `op_load_in` in 1: 1 = load, 0 = store.
- `func3_in` in 3: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `addr_in` in ADDR_W: effective byte address.
- `store_data_in` in 32: rs2 value.
- `rd_in` in 5: load destination register.
- `mem_req_out` out 1, `mem_we_out` out 1, `mem_addr_out` out ADDR_W (word-aligned, bits[1:0]=0), `mem_wdata_out` out 32, `mem_wstrb_out` out 4: data-memory request.
- `mem_ack_in` in 1, `mem_rdata_in` in 32: data-memory response; `mem_rdata_in` is valid in the ack cycle.
- `reg_we_out` out 1, `reg_write_addr_out` out 5, `reg_write_data_out` out 32: write-back to the register file.
- `hold_flag_out` out 1: pipeline stall request.
- `err_out` out 1: one-cycle error pulse (misaligned address, illegal funct3, or timeout).

## Operation
- FSM states: IDLE, REQ, RESP, ERR.
- **IDLE**
  - `req_ready_out`=1.
  - On `req_valid_in`, latch op, funct3, addr, data and rd.
  - Legal and aligned operation → REQ. Illegal or misaligned operation → ERR.
- **Legality**
  - Loads: funct3 ∈ {0,1,2,4,5}.
  - Stores: funct3 ∈ {0,1,2}.
- **Alignment**
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=0.
- **REQ**
  - `mem_req_out`=1; address, `mem_we_out`, wdata and wstrb stay stable until the ack.
  - On `mem_ack_in`: a load captures the extracted data and goes to RESP; a store goes to IDLE.
  - If the wait counter reaches TIMEOUT without an ack → ERR.
- **RESP**
  - `reg_we_out`=1 for exactly one cycle, except when rd=0 (then `reg_we_out` stays 0).
  - → IDLE.
- **ERR**
  - `err_out`=1 for one cycle; no bus request and no write-back.
  - → IDLE.
- **Store lanes** (o = addr[1:0])
  - SB: wstrb = 1<<o; wdata = the byte replicated ×4.
  - SH: wstrb = 4'b0011 when o=0, 4'b1100 when o=2; wdata = the halfword replicated ×2.
  - SW: wstrb = 4'b1111.
- **Load extract**
  - Select the byte or halfword lane by addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- `hold_flag_out` = (state != IDLE) | (IDLE & `req_valid_in`). It is combinational so the stage behind stalls in the same cycle.
- `mem_ack_in` is ignored outside REQ.

## Timing
- Reset values: state=IDLE; `mem_req_out`, `mem_we_out`, `reg_we_out`, `err_out`=0; all data, address and strobe outputs = 0; timeout counter = 0.
- A reset asserted in any state aborts the transaction. `mem_req_out` is low the cycle after reset is sampled, and a late ack is ignored.
- Accept at cycle 0 → `mem_req_out` high from cycle 1.
- Ack at cycle k≥1:
  - Load: write-back at cycle k+1.
  - Store: `req_ready_out` is high again at cycle k+1.
- Minimum latency: load 3 cycles accept-to-ready (write at cycle 2); store 2 cycles.
- Error path: `err_out` at cycle 1, ready at cycle 2.
- Timeout counter: cleared on entry to REQ, increments each REQ cycle without an ack. Abort fires when the count equals TIMEOUT.
- An ack arriving in the same cycle the count reaches TIMEOUT counts as success (ack has priority).
- Only one transaction is outstanding at a time; a new request cannot be accepted in the ack cycle.

## Structure
- Shared defines: LSU state encodings, funct3 load/store codes (next to the existing INST_FUNC3 macros), and the default TIMEOUT value.
- Sub-module `core_lsu_align`: purely combinational. It computes the store lane placement and strobes, the load extract and extension, and the legal/aligned flag. It is instantiated once.
- `core_lsu` holds only the FSM, the operand latches and the timeout counter.
- Instantiated in the core top level, fed by the execute-stage outputs. `hold_flag_out` feeds the PC register hold input.

## Test plan
- LW addr 0x100, ack at cycle 1, rdata 0xDEADBEEF → `reg_we_out` at cycle 2 with data 0xDEADBEEF; `mem_addr_out`=0x100.
- LB addr 0x103, rdata 0x80AABBCC → data 0xFFFFFF80. LBU same address → 0x00000080. LH addr 0x102 → 0xFFFF80AA.
- SH addr 0x202, data 0x1234 → wstrb 4'b1100, wdata 0x12341234, `mem_we_out`=1. SB addr 0x201, data 0xAB → wstrb 4'b0010, wdata 0xABABABAB.
- LW addr 0x101 → `err_out` pulse at cycle 1, no `mem_req_out`, no write. Load funct3=3 → same behaviour.
- Ack withheld with TIMEOUT=4 → `err_out` asserted, then IDLE. A second run with ack in the 4th REQ cycle → normal write-back.
- `rst` asserted in REQ, ack two cycles later → no write-back, `mem_req_out` low, `req_ready_out`=1. LW with rd=0 → bus access performed, `reg_we_out` stays 0.

Source files
------------

// File: rtl/core_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I funct3 codes,
// default bus timeout and the operation legality check.
package core_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_ERR  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam int LSU_TIMEOUT_DEFAULT = 255;

  // funct3[1:0] encodes the access size for every legal load and store.
  function automatic logic op_legal(input logic op_load, input logic [2:0] f3,
                                    input logic [1:0] offset);
    logic code_ok;
    logic align_ok;
    if (op_load) code_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                           (f3 == F3_LBU) || (f3 == F3_LHU);
    else         code_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    case (f3[1:0])
      2'd1:    align_ok = ~offset[0];
      2'd2:    align_ok = (offset == 2'd0);
      default: align_ok = 1'b1;
    endcase
    return code_ok & align_ok;
  endfunction

endpackage

// File: rtl/core_lsu_if.sv
// Execute-stage request, data-memory bus and register write-back signals of the LSU.
// Request handshake: an op transfers on a rising edge where req_valid_in and req_ready_out are both high.
interface core_lsu_if #(parameter int ADDR_W = 32);
  logic              req_valid_in;
  logic              req_ready_out;
  logic              op_load_in;
  logic [2:0]        func3_in;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0]       store_data_in;
  logic [4:0]        rd_in;
  logic              mem_req_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [31:0]       mem_wdata_out;
  logic [3:0]        mem_wstrb_out;
  logic              mem_ack_in;
  logic [31:0]       mem_rdata_in;
  logic              reg_we_out;
  logic [4:0]        reg_write_addr_out;
  logic [31:0]       reg_write_data_out;
  logic              hold_flag_out;
  logic              err_out;

  modport master (
    input  req_valid_in, op_load_in, func3_in, addr_in, store_data_in, rd_in,
           mem_ack_in, mem_rdata_in,
    output req_ready_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
           mem_wstrb_out, reg_we_out, reg_write_addr_out, reg_write_data_out,
           hold_flag_out, err_out
  );

  modport slave (
    output req_valid_in, op_load_in, func3_in, addr_in, store_data_in, rd_in,
           mem_ack_in, mem_rdata_in,
    input  req_ready_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
           mem_wstrb_out, reg_we_out, reg_write_addr_out, reg_write_data_out,
           hold_flag_out, err_out
  );
endinterface

// File: rtl/core_lsu_align.sv
// Combinational lane logic: store byte-lane placement and strobes, load lane
// extraction with sign/zero extension, and the legal-and-aligned flag.
module core_lsu_align
  import core_lsu_pkg::*;
(
  input  logic        op_load,
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    legal    = op_legal(op_load, func3, offset);
    wdata    = store_data;
    wstrb    = 4'b1111;
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    // Replicating the data lets the strobes alone pick the written lane.
    case (func3[1:0])
      2'd0: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << offset;
      end
      2'd1: begin
        wdata = {2{store_data[15:0]}};
        wstrb = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase

    case (func3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: single-outstanding req/ack memory bus, lane alignment,
// load write-back, pipeline hold and error pulse on bad op or bus timeout.
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  core_lsu_if.master  bus,
  output lsu_state_e  dbg_state
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e        state;
  lsu_state_e        state_nx;
  logic              op_load_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       ldata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              idle;
  logic              accept;
  logic              in_req;
  logic              ack;
  logic              al_op_load;
  logic [2:0]        al_f3;
  logic [1:0]        al_offset;
  logic [31:0]       al_sdata;
  logic              al_legal;
  logic [31:0]       al_wdata;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_ldata;

  assign idle      = (state == LSU_IDLE);
  assign in_req    = (state == LSU_REQ);
  assign accept    = idle & bus.req_valid_in;
  assign ack       = in_req & bus.mem_ack_in;
  assign dbg_state = state;

  // The single aligner sees the incoming op while idle (legality decision)
  // and the latched op afterwards (lanes, strobes, load extract).
  assign al_op_load = idle ? bus.op_load_in           : op_load_q;
  assign al_f3      = idle ? bus.func3_in             : f3_q;
  assign al_offset  = idle ? bus.addr_in[1:0]         : addr_q[1:0];
  assign al_sdata   = idle ? bus.store_data_in        : sdata_q;

  core_lsu_align u_align (
    .op_load    (al_op_load),
    .func3      (al_f3),
    .offset     (al_offset),
    .store_data (al_sdata),
    .rdata      (bus.mem_rdata_in),
    .legal      (al_legal),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .load_data  (al_ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LSU_IDLE;
      op_load_q <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
      rd_q      <= '0;
      ldata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_load_q <= bus.op_load_in;
        f3_q      <= bus.func3_in;
        addr_q    <= bus.addr_in;
        sdata_q   <= bus.store_data_in;
        rd_q      <= bus.rd_in;
        cnt_q     <= '0;
      end else if (in_req && !bus.mem_ack_in) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (ack && op_load_q) ldata_q <= al_ldata;
    end
  end

  always_comb begin
    state_nx               = state;
    bus.req_ready_out      = idle;
    bus.hold_flag_out      = !idle || bus.req_valid_in;
    bus.mem_req_out        = 1'b0;
    bus.mem_we_out         = 1'b0;
    bus.mem_addr_out       = '0;
    bus.mem_wdata_out      = '0;
    bus.mem_wstrb_out      = '0;
    bus.reg_we_out         = 1'b0;
    bus.reg_write_addr_out = '0;
    bus.reg_write_data_out = '0;
    bus.err_out            = 1'b0;

    case (state)
      LSU_IDLE: begin
        if (bus.req_valid_in) state_nx = al_legal ? LSU_REQ : LSU_ERR;
      end
      LSU_REQ: begin
        bus.mem_req_out   = 1'b1;
        bus.mem_we_out    = !op_load_q;
        bus.mem_addr_out  = {addr_q[ADDR_W-1:2], 2'b00};
        bus.mem_wdata_out = op_load_q ? 32'd0 : al_wdata;
        bus.mem_wstrb_out = op_load_q ? 4'd0 : al_wstrb;
        // Ack wins over the abort when both land in the same cycle.
        if (bus.mem_ack_in)                     state_nx = op_load_q ? LSU_RESP : LSU_IDLE;
        else if (cnt_q == CNT_W'(TIMEOUT - 1))  state_nx = LSU_ERR;
      end
      LSU_RESP: begin
        bus.reg_we_out         = (rd_q != 5'd0);
        bus.reg_write_addr_out = rd_q;
        bus.reg_write_data_out = ldata_q;
        state_nx               = LSU_IDLE;
      end
      LSU_ERR: begin
        bus.err_out = 1'b1;
        state_nx    = LSU_IDLE;
      end
      default: state_nx = LSU_IDLE;
    endcase
  end

endmodule
